mux_arb_reg: RTL and testbench



---
 rtl/mux_arb_reg.sv | 114 +++++++++++
 tb/tb_mux_arb_reg.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mux_arb_reg.sv
// mux_arb_reg
//   N-channel, W-bit selector with a registered output stage and
//   valid/ready handshakes. Channels are chosen either directly by `sl`
//   (mode=0) or by a round-robin arbiter (mode=1). The chosen word is
//   held in an output register until the consumer takes it.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   mode      0 = direct select by sl, 1 = round-robin arbitration
//   sl        channel select (mode=0 only); values >= CHANNELS grant nothing
//   in_data   channel k occupies bits [k*WIDTH +: WIDTH]
//   in_valid  per-channel data valid
//   in_ready  per-channel accept, one-hot or zero
//   o         registered selected word
//   o_valid   o holds an unconsumed word
//   o_ready   consumer accepts o this cycle
//   o_chan    index of the channel that supplied o
module mux_arb_reg #(
   parameter int WIDTH    = 4,
   parameter int CHANNELS = 8,
   parameter int SELW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      mode,
   input  logic [SELW-1:0]           sl,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   output logic [WIDTH-1:0]          o,
   output logic                      o_valid,
   input  logic                      o_ready,
   output logic [SELW-1:0]           o_chan
);

   logic [SELW-1:0]           ptr;
   logic                      free;
   logic                      grant;
   logic [SELW-1:0]           g;
   logic                      rr_found;
   logic [SELW-1:0]           rr_idx;
   logic                      sl_ok;
   logic [CHANNELS-1:0]       vld_shift;
   logic [CHANNELS-1:0]       sl_shift;
   logic [CHANNELS*WIDTH-1:0] data_shift;
   int unsigned               k;

   // The output register can take a new word whenever it is empty or
   // being drained in this same cycle.
   assign free = !o_valid || o_ready;

   // Round-robin search starting at ptr. The index is wrapped by hand so
   // that non-power-of-two channel counts never look past CHANNELS-1.
   always_comb begin
      rr_found  = 1'b0;
      rr_idx    = '0;
      k         = 0;
      vld_shift = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         k = int'(ptr) + i;
         if (k >= CHANNELS) k = k - CHANNELS;
         vld_shift = in_valid >> k;
         if (!rr_found && vld_shift[0]) begin
            rr_found = 1'b1;
            rr_idx   = SELW'(k);
         end
      end
   end

   // Direct select; an out-of-range sl simply produces no grant.
   assign sl_ok    = (int'(sl) < CHANNELS);
   assign sl_shift = in_valid >> sl;

   always_comb begin
      grant = 1'b0;
      g     = '0;
      if (mode) begin
         grant = rr_found;
         g     = rr_idx;
      end else begin
         grant = sl_ok && sl_shift[0];
         g     = sl;
      end
   end

   always_comb begin
      in_ready = '0;
      if (!rst && free && grant) in_ready = CHANNELS'(1) << g;
   end

   assign data_shift = in_data >> (int'(g) * WIDTH);

   // Output register stage. Holding when not free keeps a word stable
   // regardless of later changes to mode, sl or in_data.
   always_ff @(posedge clk) begin
      if (rst) begin
         o       <= '0;
         o_chan  <= '0;
         o_valid <= 1'b0;
         ptr     <= '0;
      end else if (free) begin
         if (grant) begin
            o       <= data_shift[WIDTH-1:0];
            o_chan  <= g;
            o_valid <= 1'b1;
            if (mode) ptr <= (int'(g) == CHANNELS - 1) ? '0 : g + 1'b1;
         end else begin
            o_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mux_arb_reg.sv
// tb_mux_arb_reg
//   Directed bench for mux_arb_reg: an 8-channel instance and a
//   5-channel instance sharing clock and reset. Expected values are
//   hand-computed from the behaviour of the selector.
module tb_mux_arb_reg;

   logic        clk = 1'b0;
   logic        rst;

   // 8-channel x 4-bit instance
   logic        mode;
   logic [2:0]  sl;
   logic [31:0] in_data;
   logic [7:0]  in_valid;
   logic [7:0]  in_ready;
   logic [3:0]  o;
   logic        o_valid;
   logic        o_ready;
   logic [2:0]  o_chan;

   // 5-channel x 4-bit instance
   logic        b_mode;
   logic [2:0]  b_sl;
   logic [19:0] b_in_data;
   logic [4:0]  b_in_valid;
   logic [4:0]  b_in_ready;
   logic [3:0]  b_o;
   logic        b_o_valid;
   logic        b_o_ready;
   logic [2:0]  b_o_chan;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mux_arb_reg #(.WIDTH(4), .CHANNELS(8)) dut (
      .clk(clk), .rst(rst), .mode(mode), .sl(sl), .in_data(in_data),
      .in_valid(in_valid), .in_ready(in_ready), .o(o), .o_valid(o_valid),
      .o_ready(o_ready), .o_chan(o_chan)
   );

   mux_arb_reg #(.WIDTH(4), .CHANNELS(5)) dut5 (
      .clk(clk), .rst(rst), .mode(b_mode), .sl(b_sl), .in_data(b_in_data),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .o(b_o), .o_valid(b_o_valid),
      .o_ready(b_o_ready), .o_chan(b_o_chan)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // channel k of the 8-channel instance carries 15-k
      rst = 1'b1; mode = 1'b1; sl = 3'd0; in_data = 32'h89ABCDEF;
      in_valid = 8'hFF; o_ready = 1'b1;
      b_mode = 1'b1; b_sl = 3'd0; b_in_data = 20'h54321;
      b_in_valid = 5'h00; b_o_ready = 1'b1;

      #1;
      check("rst_in_ready_comb", 32'(in_ready), 32'h00);
      for (int i = 0; i < 2; i++) begin
         tick();
         check("rst_o", 32'(o), 32'h0);
         check("rst_o_valid", 32'(o_valid), 32'h0);
         check("rst_o_chan", 32'(o_chan), 32'h0);
         check("rst_in_ready", 32'(in_ready), 32'h00);
         check("rst5_o_valid", 32'(b_o_valid), 32'h0);
      end

      rst = 1'b0;
      #1;
      check("first_grant_ready", 32'(in_ready), 32'h01);

      // round-robin over all eight channels, ten grants
      for (int i = 0; i < 10; i++) begin
         tick();
         check("rr_chan", 32'(o_chan), 32'(i % 8));
         check("rr_data", 32'(o), 32'(15 - (i % 8)));
         check("rr_valid", 32'(o_valid), 32'h1);
      end

      // ptr is now 2: only channels 0 and 7 valid -> 7,0,7,0
      in_valid = 8'h81;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("rr81_chan", 32'(o_chan), (i % 2 == 0) ? 32'd7 : 32'd0);
      end

      // direct select of channel 5
      mode = 1'b0; sl = 3'd5; in_valid = 8'hFF;
      #1;
      check("direct_in_ready", 32'(in_ready), 32'h20);
      tick();
      check("direct_o", 32'(o), 32'hA);
      check("direct_chan", 32'(o_chan), 32'd5);
      check("direct_valid", 32'(o_valid), 32'h1);

      // backpressure: load channel 3, then stall four cycles
      sl = 3'd3;
      tick();
      check("bp_load_chan", 32'(o_chan), 32'd3);
      o_ready = 1'b0;
      #1;
      check("bp_in_ready", 32'(in_ready), 32'h00);
      in_data = 32'h12345678;
      for (int i = 0; i < 4; i++) begin
         sl = 3'(i + 4);
         mode = i[0];
         tick();
         check("bp_o", 32'(o), 32'hC);
         check("bp_chan", 32'(o_chan), 32'd3);
         check("bp_valid", 32'(o_valid), 32'h1);
         check("bp_ready", 32'(in_ready), 32'h00);
      end
      mode = 1'b0; sl = 3'd6; o_ready = 1'b1;
      #1;
      check("bp_release_ready", 32'(in_ready), 32'h40);
      tick();
      check("bp_release_o", 32'(o), 32'h2);
      check("bp_release_chan", 32'(o_chan), 32'd6);
      check("bp_release_valid", 32'(o_valid), 32'h1);

      // drain to idle
      in_data = 32'h89ABCDEF;
      in_valid = 8'h00;
      tick();
      check("drain_valid", 32'(o_valid), 32'h0);
      check("drain_o_kept", 32'(o), 32'h2);
      check("drain_chan_kept", 32'(o_chan), 32'd6);

      // ptr is 1: a mode=0 grant must leave it untouched
      mode = 1'b1; in_valid = 8'hFF;
      tick();
      check("sw_rr_chan", 32'(o_chan), 32'd1);
      mode = 1'b0; sl = 3'd2;
      tick();
      check("sw_direct_chan", 32'(o_chan), 32'd2);
      check("sw_direct_o", 32'(o), 32'hD);
      mode = 1'b1;
      tick();
      check("sw_ptr_unchanged", 32'(o_chan), 32'd2);

      // five channels: wrap after channel 4
      in_valid = 8'h00;
      b_in_valid = 5'h1F;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("np2_chan", 32'(b_o_chan), 32'(i % 5));
         check("np2_o", 32'(b_o), 32'((i % 5) + 1));
      end
      b_mode = 1'b0; b_sl = 3'd6;
      #1;
      check("np2_oob_ready", 32'(b_in_ready), 32'h00);
      tick();
      check("np2_oob_valid", 32'(b_o_valid), 32'h0);
      check("np2_oob_o_kept", 32'(b_o), 32'h1);

      // reset while a word is held
      in_valid = 8'hFF; mode = 1'b1;
      tick();
      o_ready = 1'b0;
      rst = 1'b1;
      #1;
      check("midrst_ready", 32'(in_ready), 32'h00);
      tick();
      check("midrst_valid", 32'(o_valid), 32'h0);
      check("midrst_o", 32'(o), 32'h0);
      check("midrst_chan", 32'(o_chan), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
